qpsk_symbol_mapper: RTL and testbench
=====================================

QPSK_SYMBOL_MAPPER -- requirements
Module: qpsk_symbol_mapper

Interface
REQ-001 The block SHALL take the parameter N, default 4, as the number of output samples emitted per input symbol (1..64).
REQ-002 The block SHALL take the parameter AMP, default 16'sd23170, as the signed constellation magnitude (about 0.707 full scale).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 ce_clk  in  1  clock; all logic is rising-edge.
REQ-005 ce_rst_n  in  1  asynchronous active-low reset.
REQ-006 s_axis_tdata  in  32  input item; bits [1:0] are the dibit {b1,b0}; bits [31:2] are ignored.
REQ-007 s_axis_tlast  in  1  end of input packet.
REQ-008 s_axis_tvalid  in  1  input valid.
REQ-009 s_axis_tready  out  1  input ready.
REQ-010 m_axis_tdata  out  32  output sample; {I[31:16], Q[15:0]}, both signed 16-bit.
REQ-011 m_axis_tlast  out  1  end of output packet.
REQ-012 m_axis_tvalid  out  1  output valid.
REQ-013 m_axis_tready  in  1  output ready.

Function
REQ-014 The mapping SHALL be Gray-coded: I = b1 ? -AMP : +AMP; Q = b0 ? -AMP : +AMP.
REQ-015 The block SHALL have a two-state FSM, IDLE (nothing held) and EMIT (symbol held, phase counter 0..N-1).
REQ-016 In IDLE, s_axis_tready SHALL be 1; an input transfer latches the mapped sample and tlast, clears phase to 0, and enters EMIT.
REQ-017 m_axis_tvalid SHALL be 1 exactly in EMIT, with registered tdata; the first output is valid one cycle after input acceptance.
REQ-018 Each output transfer in EMIT SHALL increment phase.
REQ-019 An output transfer at phase N-1 SHALL complete the symbol.
REQ-020 s_axis_tready SHALL equal (state==IDLE) || (m_axis_tready && phase==N-1), so back-to-back symbols stream without a bubble.
REQ-021 If a symbol completes and an input transfer occurs in the same cycle, the block SHALL load the new symbol, reset phase to 0 and stay in EMIT.
REQ-022 If a symbol completes with no input transfer, the block SHALL return to IDLE.
REQ-023 m_axis_tlast SHALL be 1 only at phase N-1 of a symbol whose input carried tlast; every other repeat carries tlast=0.
REQ-024 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and phase SHALL hold stable.
REQ-025 m_axis_tvalid SHALL never depend combinationally on m_axis_tready.
REQ-026 With N=1, throughput SHALL be one sample per cycle when both sides are ready.
REQ-027 Output words SHALL be exactly sign-correct 16-bit values with no saturation or rounding; -AMP is the two's complement of AMP.

Reset
REQ-028 While ce_rst_n=0: state=IDLE, phase=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, and s_axis_tready=0 (forced low during reset).
REQ-029 Reset asserted mid-EMIT SHALL discard the held symbol immediately, with no further output beats.
REQ-030 s_axis_tready SHALL rise no earlier than the first ce_clk edge after ce_rst_n deasserts.

Structure
REQ-031 The shared package qpsk_pkg SHALL hold: typedef iq_t (packed struct {logic signed [15:0] i, q}), constant QPSK_AMP_DEFAULT = 23170, and function qpsk_map(dibit, amp) returning iq_t.
REQ-032 The FSM and phase counter SHALL live in this module; no sub-module is needed.
REQ-033 The phase counter width SHALL be $clog2(N) bits, minimum 1.

Verification
REQ-034 Bench scenario (dibit table): with N=4 and no stalls, send dibits 0,1,2,3 -> 16 beats: 4x0x5A825A82, 4x0x5A82A57E, 4x0xA57E5A82, 4x0xA57EA57E.
REQ-035 Bench scenario (packet end): send 2 items with tlast on item 2 -> tlast only on output beat 8; beats 1-7 have tlast=0.
REQ-036 Bench scenario (random stall): 25% random stall on m_axis_tready during 64 symbols -> output count 256, order preserved, data stable whenever tvalid=1 and tready=0.
REQ-037 Bench scenario (back-to-back): continuous input at N=4 -> s_axis_tready pulses once every 4 output beats, with no idle cycle between symbols.
REQ-038 Bench scenario (N=1): 100 random dibits -> 100 outputs on consecutive cycles, each equal to qpsk_map.
REQ-039 Bench scenario (mid-reset): assert ce_rst_n=0 at phase 2 -> m_axis_tvalid=0 the same cycle; after release, the next output is the first repeat of the next accepted symbol.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared QPSK types and the Gray-coded dibit-to-constellation mapping.
package qpsk_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned AXIS_W   = 32;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } iq_t;

  localparam logic signed [SAMPLE_W-1:0] QPSK_AMP_DEFAULT = 16'sd23170;

  // b1 selects the sign of I, b0 the sign of Q; -amp is the exact two's complement
  function automatic iq_t qpsk_map(input logic [1:0] dibit,
                                   input logic signed [SAMPLE_W-1:0] amp);
    iq_t s;
    s.i = dibit[1] ? SAMPLE_W'(-amp) : amp;
    s.q = dibit[0] ? SAMPLE_W'(-amp) : amp;
    return s;
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper_if.sv
// Stream channel carrying 32-bit items with valid/ready/last handshake.
interface qpsk_symbol_mapper_if;
  import qpsk_pkg::*;

  logic [AXIS_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/qpsk_symbol_mapper.sv
// QPSK mapper: each accepted dibit becomes N repeated {I,Q} samples, with
// the symbol's tlast marked only on its final repeat.
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int unsigned                N   = 4,
  parameter logic signed [SAMPLE_W-1:0] AMP = QPSK_AMP_DEFAULT
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst_n,
  qpsk_symbol_mapper_if.slave  s_axis,
  qpsk_symbol_mapper_if.master m_axis
);

  localparam int unsigned    PW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0]  LAST_PHASE = PW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  iq_t           data_q, data_d;
  logic          sym_last_q, sym_last_d;
  logic          tlast_q, tlast_d;
  logic          rst_done_q;

  logic last_phase_c;
  logic s_ready_c;
  logic s_fire_c;
  logic m_fire_c;
  logic unused_tdata_c;

  assign last_phase_c = (phase_q == LAST_PHASE);
  // Input opens only when idle or when the final repeat leaves this cycle
  assign s_ready_c = rst_done_q &
                     ((state_q == IDLE) |
                      ((state_q == EMIT) & m_axis.tready & last_phase_c));
  assign s_fire_c  = s_axis.tvalid & s_ready_c;
  assign m_fire_c  = (state_q == EMIT) & m_axis.tready;

  assign unused_tdata_c = ^s_axis.tdata[AXIS_W-1:2];

  // Holds input ready low until the first clock edge after reset release
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) rst_done_q <= 1'b0;
    else           rst_done_q <= 1'b1;
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      data_q     <= '0;
      sym_last_q <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      data_q     <= data_d;
      sym_last_q <= sym_last_d;
      tlast_q    <= tlast_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    data_d     = data_q;
    sym_last_d = sym_last_q;

    case (state_q)
      IDLE: begin
        if (s_fire_c) state_d = EMIT;
      end
      EMIT: begin
        if (m_fire_c) begin
          if (!last_phase_c) begin
            phase_d = phase_q + PW'(1);
          end else if (!s_fire_c) begin
            state_d    = IDLE;
            phase_d    = '0;
            sym_last_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new symbol can only be accepted from IDLE or on the final repeat
    if (s_fire_c) begin
      state_d    = EMIT;
      phase_d    = '0;
      data_d     = qpsk_map(s_axis.tdata[1:0], AMP);
      sym_last_d = s_axis.tlast;
    end

    tlast_d = sym_last_d & (state_d == EMIT) & (phase_d == LAST_PHASE);
  end

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = (state_q == EMIT);
  assign m_axis.tdata  = data_q;
  assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Directed bench for qpsk_symbol_mapper with N=4 and N=1 instances.
module tb_qpsk_symbol_mapper;

  logic        clk;
  logic        rst4_n, rst1_n;
  logic        sel;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, m_tready;

  int errors;
  int checks;

  logic [1:0] dib [0:127];
  bit         lst [0:127];

  qpsk_symbol_mapper_if sif4();
  qpsk_symbol_mapper_if mif4();
  qpsk_symbol_mapper_if sif1();
  qpsk_symbol_mapper_if mif1();

  qpsk_symbol_mapper #(.N(4)) dut4 (
    .ce_clk(clk), .ce_rst_n(rst4_n), .s_axis(sif4), .m_axis(mif4));
  qpsk_symbol_mapper #(.N(1)) dut1 (
    .ce_clk(clk), .ce_rst_n(rst1_n), .s_axis(sif1), .m_axis(mif1));

  assign sif4.tdata  = s_tdata;
  assign sif4.tlast  = s_tlast;
  assign sif4.tvalid = s_tvalid & ~sel;
  assign mif4.tready = m_tready & ~sel;
  assign sif1.tdata  = s_tdata;
  assign sif1.tlast  = s_tlast;
  assign sif1.tvalid = s_tvalid & sel;
  assign mif1.tready = m_tready & sel;

  wire        i_ready = sel ? sif1.tready : sif4.tready;
  wire        o_valid = sel ? mif1.tvalid : mif4.tvalid;
  wire        o_last  = sel ? mif1.tlast  : mif4.tlast;
  wire [31:0] o_data  = sel ? mif1.tdata  : mif4.tdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // 23170 = 0x5A82, -23170 = 0xA57E
  function automatic logic [31:0] expw(input logic [1:0] d);
    logic [15:0] p, m;
    p = 16'h5A82;
    m = 16'hA57E;
    return {d[1] ? m : p, d[0] ? m : p};
  endfunction

  // Streams dib/lst[0..nsym-1] into the selected DUT and scores every beat
  task automatic run(input int nsym, input int stall_pct, input bit b2b);
    int n, total, sent, got, cyc, bubbles, misalign, acc_cyc, idx;
    bit started, stalled;
    logic [31:0] hold_d;
    logic        hold_l;
    n = sel ? 1 : 4;
    total = nsym * n;
    sent = 0; got = 0; cyc = 0; bubbles = 0; misalign = 0; acc_cyc = 0;
    started = 0; stalled = 0; hold_d = '0; hold_l = 1'b0;
    while (got < total && cyc < 4000) begin
      @(negedge clk);
      idx      = (sent < nsym) ? sent : 0;
      s_tvalid = (sent < nsym);
      s_tdata  = $urandom();
      s_tdata[1:0] = dib[idx];
      s_tlast  = lst[idx];
      m_tready = ($urandom_range(99) >= 32'(stall_pct));
      #1;
      if (stalled && o_valid) begin
        check("stall_data", o_data, hold_d);
        check("stall_last", 32'(o_last), 32'(hold_l));
      end
      if (o_valid && !started) begin
        check("first_latency", 32'(cyc - acc_cyc), 32'd1);
        started = 1;
      end
      if (o_valid && m_tready) begin
        check("beat_data", o_data, expw(dib[got / n]));
        check("beat_last", 32'(o_last), 32'(lst[got / n] && (got % n == n - 1)));
        if (b2b && s_tvalid && i_ready && sent > 0 && (got % n != n - 1)) misalign++;
        got++;
      end else if (started && b2b && !o_valid) begin
        bubbles++;
      end
      stalled = o_valid && !m_tready;
      hold_d  = o_data;
      hold_l  = o_last;
      if (s_tvalid && i_ready) begin
        if (sent == 0) acc_cyc = cyc;
        sent++;
      end
      cyc++;
    end
    check("beat_count", 32'(got), 32'(total));
    if (b2b) begin
      check("bubbles", 32'(bubbles), 32'd0);
      check("ready_align", 32'(misalign), 32'd0);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    sel = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    rst4_n = 1'b0; rst1_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_last",  32'(o_last),  32'd0);
      check("rst_data",  o_data,       32'd0);
      check("rst_ready", 32'(i_ready), 32'd0);
    end
    sel = 1'b0;
    rst4_n = 1'b1; rst1_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(i_ready), 32'd1);

    // Dibit table, no stalls
    for (int k = 0; k < 4; k++) begin dib[k] = 2'(k); lst[k] = 1'b0; end
    run(4, 0, 1);

    // Packet end: tlast only on beat 8
    dib[0] = 2'd1; lst[0] = 1'b0;
    dib[1] = 2'd2; lst[1] = 1'b1;
    run(2, 0, 0);

    // Back-to-back continuous input
    for (int k = 0; k < 8; k++) begin dib[k] = 2'($urandom()); lst[k] = (k == 7); end
    run(8, 0, 1);

    // 25% random output stall over 64 symbols
    for (int k = 0; k < 64; k++) begin dib[k] = 2'($urandom()); lst[k] = 1'($urandom()); end
    run(64, 25, 0);

    // Reset asserted at phase 2 of a held symbol
    @(negedge clk);
    s_tdata = 32'h0000_0002; s_tlast = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    check("mid_phase0", o_data, 32'hA57E_5A82);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_phase2_valid", 32'(o_valid), 32'd1);
    rst4_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_data",  o_data,       32'd0);
    check("mid_rst_last",  32'(o_last),  32'd0);
    check("mid_rst_ready", 32'(i_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_hold", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    dib[0] = 2'd1; lst[0] = 1'b0;
    run(1, 0, 0);

    // N=1: one sample per cycle
    sel = 1'b1;
    for (int k = 0; k < 100; k++) begin dib[k] = 2'($urandom()); lst[k] = 1'($urandom()); end
    run(100, 0, 1);

    @(negedge clk);
    s_tvalid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
